// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I core.
// Holds the word type, instruction alignment and the default reset PC.
package rv32i_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_ALIGN      = 2;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/rv32i_imem.sv
// Instruction memory: one synchronous write port, one registered read port.
// Ports: clk_i, rst_ni (sync, clears read data only), wr_*_i, rd_*_i, rd_data_o.
module rv32i_imem
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [31:0]   wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [31:0]   rd_data_o
);

    word_t mem_q [DEPTH];
    word_t rd_q;

    // Contents are never reset; the loader owns them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read register doubles as the stage's instruction output,
    // so it holds whenever no read is requested.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/rv32i_instruction_fetch_stage.sv
// Fetch stage: owns the PC, the host write-ack flag and the output registers.
// Ports: clock/reset, branch redirect, decode handshake, fetch outputs, host write port.
module rv32i_instruction_fetch_stage
    import rv32i_pkg::*;
#(
    parameter int          IMEM_DEPTH = 512,
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_branch_pc,
    input  logic        i_branch_miss,
    input  logic        i_decode_ready,
    output logic        o_instruction_latch_en,
    output logic [31:0] o_fetch_instruction,
    output logic [31:0] o_fetch_instruction_pc,
    input  logic        i_instruction_wr_en,
    input  logic [31:0] i_instruction_wr_addr,
    input  logic [31:0] i_instruction_wr_data,
    output logic        o_instruction_wr_valid
);

    localparam int AW = $clog2(IMEM_DEPTH);

    word_t pc_q, pc_d;
    word_t ipc_q, ipc_d;
    logic  wr_valid_q;
    logic  latch_q;
    logic  wr_accept;
    logic  fetch;
    logic  unused_addr_bits;

    // Ack cycle blocks the next accept, so a held wr_en writes every other cycle.
    assign wr_accept = i_instruction_wr_en & ~wr_valid_q;

    // Any pending host write stalls fetch, which removes read-during-write.
    assign fetch = i_decode_ready & ~i_branch_miss & ~i_instruction_wr_en;

    always_comb begin
        pc_d  = pc_q;
        ipc_d = ipc_q;
        unique case (1'b1)
            i_branch_miss: begin
                pc_d = {i_branch_pc[XLEN-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
            end
            fetch: begin
                pc_d  = pc_q + 32'd4;
                ipc_d = pc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_q       <= PC_RESET;
            ipc_q      <= '0;
            latch_q    <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            latch_q    <= fetch;
            wr_valid_q <= wr_accept;
        end
    end

    // Write is gated by reset so an accept at a reset edge is dropped.
    rv32i_imem #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .wr_en_i   (wr_accept & i_rst),
        .wr_idx_i  (i_instruction_wr_addr[AW+1:2]),
        .wr_data_i (i_instruction_wr_data),
        .rd_en_i   (fetch),
        .rd_idx_i  (pc_q[AW+1:2]),
        .rd_data_o (o_fetch_instruction)
    );

    // Address bits outside the word index are ignored by design.
    assign unused_addr_bits = ^{i_instruction_wr_addr[31:AW+2],
                                i_instruction_wr_addr[1:0],
                                i_branch_pc[1:0]};

    assign o_fetch_instruction_pc = ipc_q;
    assign o_instruction_latch_en = latch_q;
    assign o_instruction_wr_valid = wr_valid_q;

endmodule

// File: tb/tb_rv32i_instruction_fetch_stage.sv
// Self-checking bench for the fetch stage.
// Expected fetches are queued as stimulus is driven and popped per output cycle.
module tb_rv32i_instruction_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] branch_pc;
    logic        branch_miss;
    logic        decode_ready;
    logic        latch_en;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sbq[$];

    rv32i_instruction_fetch_stage #(
        .IMEM_DEPTH (512),
        .PC_RESET   (32'h0)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_branch_pc            (branch_pc),
        .i_branch_miss          (branch_miss),
        .i_decode_ready         (decode_ready),
        .o_instruction_latch_en (latch_en),
        .o_fetch_instruction    (instr),
        .o_fetch_instruction_pc (ipc),
        .i_instruction_wr_en    (wr_en),
        .i_instruction_wr_addr  (wr_addr),
        .i_instruction_wr_data  (wr_data),
        .o_instruction_wr_valid (wr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        branch_pc    = '0;
        branch_miss  = 1'b0;
        decode_ready = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        tick();
        tick();
        tests++;
        if ({latch_en, wr_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=00", {latch_en, wr_valid});
        end
        tests++;
        if ({instr, ipc} !== 64'h0) begin
            fails++;
            $display("FAIL reset_data got=%h/%h exp=0/0", instr, ipc);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (latch_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle latch got=%b exp=0", latch_en);
        end
    endtask

    task automatic test_load();
        for (int a = 0; a < 4; a++) begin
            wr_en   = 1'b1;
            wr_addr = 32'(4 * a);
            wr_data = 32'(4 * a);
            tick();
            tests++;
            if ({wr_valid, latch_en} !== 2'b10) begin
                fails++;
                $display("FAIL load_ack[%0d] got=%b exp=10", a, {wr_valid, latch_en});
            end
            if (a == 3) wr_en = 1'b0;
            tick();
            tests++;
            if ({wr_valid, latch_en} !== 2'b00) begin
                fails++;
                $display("FAIL load_gap[%0d] got=%b exp=00", a, {wr_valid, latch_en});
            end
        end
    endtask

    task automatic test_fetch();
        exp_t e;
        decode_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'(4 * i), 32'(4 * i));
            tick();
            e = sbq.pop_front();
            tests++;
            if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
                fails++;
                $display("FAIL fetch[%0d] got=%b %h/%h exp=1 %h/%h",
                         i, latch_en, instr, ipc, e.instr, e.pc);
            end
        end
        decode_ready = 1'b0;
        tick();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b0, 32'd12, 32'd12}) begin
            fails++;
            $display("FAIL fetch_hold got=%b %h/%h exp=0 c/c", latch_en, instr, ipc);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        decode_ready = 1'b1;
        push(32'd0, 32'd0);
        tick();
        e = sbq.pop_front();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
            fails++;
            $display("FAIL stall_first got=%b %h/%h exp=1 %h/%h",
                     latch_en, instr, ipc, e.instr, e.pc);
        end
        decode_ready = 1'b0;
        tick();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL stall_hold got=%b %h/%h exp=0 0/0", latch_en, instr, ipc);
        end
        decode_ready = 1'b1;
        push(32'd4, 32'd4);
        tick();
        e = sbq.pop_front();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
            fails++;
            $display("FAIL stall_resume got=%b %h/%h exp=1 %h/%h",
                     latch_en, instr, ipc, e.instr, e.pc);
        end
        decode_ready = 1'b0;
    endtask

    task automatic test_branch();
        exp_t e;
        decode_ready = 1'b1;
        push(32'd8, 32'd8);
        tick();
        e = sbq.pop_front();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
            fails++;
            $display("FAIL branch_pre got=%b %h/%h exp=1 %h/%h",
                     latch_en, instr, ipc, e.instr, e.pc);
        end
        // Misaligned target: low bits must be dropped.
        branch_miss = 1'b1;
        branch_pc   = 32'h0000_000A;
        tick();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b0, 32'd8, 32'd8}) begin
            fails++;
            $display("FAIL branch_bubble got=%b %h/%h exp=0 8/8", latch_en, instr, ipc);
        end
        branch_miss = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(32'(8 + 4 * i), 32'(8 + 4 * i));
            tick();
            e = sbq.pop_front();
            tests++;
            if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
                fails++;
                $display("FAIL branch_tgt[%0d] got=%b %h/%h exp=1 %h/%h",
                         i, latch_en, instr, ipc, e.instr, e.pc);
            end
        end
        decode_ready = 1'b0;
    endtask

    task automatic test_write_priority();
        exp_t e;
        // pc is 16 here; a write with decode ready must stall fetch.
        decode_ready = 1'b1;
        wr_en        = 1'b1;
        wr_addr      = 32'd16;
        wr_data      = 32'hCAFE_0013;
        tick();
        tests++;
        if ({latch_en, wr_valid} !== 2'b01) begin
            fails++;
            $display("FAIL wrprio_ack got=%b exp=01", {latch_en, wr_valid});
        end
        tick();
        tests++;
        if ({latch_en, wr_valid} !== 2'b00) begin
            fails++;
            $display("FAIL wrprio_gap got=%b exp=00", {latch_en, wr_valid});
        end
        wr_en = 1'b0;
        push(32'hCAFE_0013, 32'd16);
        tick();
        e = sbq.pop_front();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
            fails++;
            $display("FAIL wrprio_resume got=%b %h/%h exp=1 %h/%h",
                     latch_en, instr, ipc, e.instr, e.pc);
        end
        // Write alongside a redirect still lands; byte offset ignored.
        branch_miss = 1'b1;
        branch_pc   = 32'd20;
        wr_en       = 1'b1;
        wr_addr     = 32'd23;
        wr_data     = 32'h1234_5678;
        tick();
        tests++;
        if ({latch_en, wr_valid} !== 2'b01) begin
            fails++;
            $display("FAIL wrbr_ack got=%b exp=01", {latch_en, wr_valid});
        end
        branch_miss = 1'b0;
        wr_en       = 1'b0;
        push(32'h1234_5678, 32'd20);
        tick();
        e = sbq.pop_front();
        tests++;
        if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
            fails++;
            $display("FAIL wrbr_fetch got=%b %h/%h exp=1 %h/%h",
                     latch_en, instr, ipc, e.instr, e.pc);
        end
        decode_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        branch_miss = 1'b1;
        branch_pc   = 32'd12;
        tick();
        branch_miss  = 1'b0;
        decode_ready = 1'b1;
        push(32'd12, 32'd12);
        push(32'hCAFE_0013, 32'd16);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sbq.pop_front();
            tests++;
            if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
                fails++;
                $display("FAIL rstmid_pre[%0d] got=%b %h/%h exp=1 %h/%h",
                         i, latch_en, instr, ipc, e.instr, e.pc);
            end
        end
        // Write at the reset edge must be dropped.
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 32'd0;
        wr_data = 32'hFFFF_FFFF;
        tick();
        tests++;
        if ({latch_en, wr_valid, instr, ipc} !== 66'h0) begin
            fails++;
            $display("FAIL rstmid_zero got=%b%b %h/%h exp=00 0/0",
                     latch_en, wr_valid, instr, ipc);
        end
        rst   = 1'b1;
        wr_en = 1'b0;
        push(32'd0, 32'd0);
        push(32'd4, 32'd4);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sbq.pop_front();
            tests++;
            if ({latch_en, instr, ipc} !== {1'b1, e.instr, e.pc}) begin
                fails++;
                $display("FAIL rstmid_post[%0d] got=%b %h/%h exp=1 %h/%h",
                         i, latch_en, instr, ipc, e.instr, e.pc);
            end
        end
        decode_ready = 1'b0;
        tick();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_stall();
        test_branch();
        test_write_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
